instr_loader: RTL
=================

Name: instr_loader

Overview:
Upstream feeder for the CPU's instruction FIFO/memory path. Accepts a framed program image as a byte stream over a valid/ready interface: sync byte, length, payload, checksum. Payload bytes go to the instruction FIFO as `wr` + `opcode`, and the block backpressures the source while the FIFO reports full. Frame success or failure is reported as one-cycle status pulses.

Parameters:
- DATA_WIDTH, 8, width of stream bytes and opcodes.
- ADDR_WIDTH, 4, instruction FIFO address width; max payload length = 2**ADDR_WIDTH.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  source presents a byte.
- in_data  input  DATA_WIDTH  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- fifo_full  input  1  instruction FIFO full flag.
- wr  output  1  FIFO write strobe.
- opcode  output  DATA_WIDTH  FIFO write data.
- busy  output  1  frame in progress (state not IDLE).
- done  output  1  one-cycle pulse: frame accepted, checksum good.
- err  output  1  one-cycle pulse: frame rejected.
- load_count  output  ADDR_WIDTH+1  payload bytes written in current/last frame.

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous and active-high. On reset: state=IDLE; done=0, err=0, load_count=0; internal length/remaining/checksum registers cleared; busy=0.
- Handshake: a byte is accepted on the cycle where `in_valid && in_ready` at the rising edge. No byte is consumed otherwise.
- in_ready (combinational):
  - 1 in IDLE, LEN, CHK.
  - In DATA: ~fifo_full.
  - 0 in DONE and ERR.
- wr and opcode (combinational, zero latency):
  - wr = in_valid && in_ready && state==DATA.
  - opcode = in_data when wr=1, else 0.
  - wr never asserts while fifo_full=1.
- FSM states: IDLE, LEN, DATA, CHK, DONE, ERR.
  - IDLE: accepted byte == SYNC_BYTE → LEN, load_count<=0, checksum<=0. Any other byte is discarded; stay in IDLE.
  - LEN: accepted byte N.
    - N==0 or N>2**ADDR_WIDTH → ERR.
    - Otherwise remaining<=N → DATA.
  - DATA: each accepted byte is written; checksum<=checksum+byte (mod 2**DATA_WIDTH); load_count++; remaining--. On the byte where remaining==1 → CHK. A SYNC_BYTE value here is ordinary payload.
  - CHK: accepted byte == checksum → DONE; otherwise → ERR.
  - DONE: done=1 for exactly one cycle → IDLE.
  - ERR: err=1 for exactly one cycle → IDLE.
- Outputs and counters:
  - done and err are registered (high only while in DONE/ERR); they are never both 1.
  - busy=1 in all states except IDLE.
  - load_count holds its value after DONE/ERR until the next sync byte is accepted.
  - Payload bytes already written before an ERR stay in the FIFO; the loader does not retract them.
- Stall: in_valid low, or fifo_full high in DATA, holds state and all counters indefinitely. No timeout.
- Reset mid-frame: returns to IDLE on the next edge; the partial frame is abandoned with no done/err pulse.
- Widths: checksum is DATA_WIDTH bits, modular sum with wrap-around. remaining and load_count are ADDR_WIDTH+1 bits so that N=2**ADDR_WIDTH is representable.

Test Plan:
1. Nominal frame: A5,03,01,02,03,06 with fifo_full=0 and in_valid held high → wr pulses on 3 consecutive cycles with opcode 01,02,03. done=1 one cycle after the 06 byte is accepted; load_count=3; err never asserts.
2. Backpressure: same frame with fifo_full=1 for 4 cycles after the first payload byte → in_ready=0 and wr=0 during those cycles. Byte 02 is held and written once fifo_full drops. Final result identical to test 1.
3. Bad checksum and discard:
   - A5,02,10,20,31 → wr for 10,20; err pulse one cycle; load_count=2; state IDLE.
   - Then 00,FF,A5,01,07,07 → leading bytes discarded, done pulse, load_count=1.
4. Length bounds:
   - A5,00 → err pulse, no wr.
   - A5,11 (17 > 16) → err pulse, no wr.
   - A5,10 with bytes 00..0F, checksum 78 → 16 writes, done, load_count=16.
5. Payload contains sync value: A5,02,A5,A5,4A → both A5 bytes written as opcodes, done pulse, checksum wraps correctly (A5+A5=14A→4A).
6. Reset mid-frame: A5,04,01,02 then reset high one cycle → no done/err. Outputs at reset values: busy=0, load_count=0, in_ready=1. A following A5,01,05,05 → done.

Source files
------------

// File: rtl/instr_loader.sv
// Framed program-image loader: parses sync/length/payload/checksum frames from a byte stream
// and forwards payload bytes to the instruction FIFO, pulsing done or err per frame.
module instr_loader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  fifo_full,
  output logic                  wr,
  output logic [DATA_WIDTH-1:0] opcode,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   load_count
);

  localparam int unsigned CntW   = ADDR_WIDTH + 1;
  localparam int unsigned MaxLen = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StChk,
    StDone,
    StErr
  } state_e;

  state_e                state_q;
  logic [CntW-1:0]       remaining_q;
  logic [CntW-1:0]       load_count_q;
  logic [DATA_WIDTH-1:0] checksum_q;
  logic                  done_q;
  logic                  err_q;

  logic accept;
  logic len_bad;

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StIdle, StLen, StChk: in_ready = 1'b1;
      StData:               in_ready = ~fifo_full;
      default:              in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid && in_ready;
  assign wr     = accept && (state_q == StData);
  assign opcode = wr ? in_data : '0;

  // Lengths are compared at 32 bits so N above the FIFO depth is caught whatever the widths.
  assign len_bad = (in_data == '0) || (32'(in_data) > MaxLen);

  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign err        = err_q;
  assign load_count = load_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      remaining_q  <= '0;
      load_count_q <= '0;
      checksum_q   <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept && (in_data == SYNC_BYTE)) begin
            state_q      <= StLen;
            load_count_q <= '0;
            checksum_q   <= '0;
          end
        end
        StLen: begin
          if (accept) begin
            if (len_bad) begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end else begin
              state_q     <= StData;
              remaining_q <= CntW'(in_data);
            end
          end
        end
        StData: begin
          if (accept) begin
            checksum_q   <= checksum_q + in_data;
            load_count_q <= load_count_q + CntW'(1);
            remaining_q  <= remaining_q - CntW'(1);
            if (remaining_q == CntW'(1)) begin
              state_q <= StChk;
            end
          end
        end
        StChk: begin
          if (accept) begin
            if (in_data == checksum_q) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StErr;
              err_q   <= 1'b1;
            end
          end
        end
        StDone, StErr: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
